rdma_meta_checker: RTL and testbench
====================================

// Module: rdma_meta_checker
// PURPOSE
//  Parametrised successor of the TX metadata validator. Sits between descriptor fetch and header build.
//  Checks each metadata beat in one cycle and buffers the results in an output FIFO, so throughput is one beat per cycle.
//  Bad beats are either dropped or forwarded with an error tag (DROP_ON_ERR).
//  Keeps saturating pass/error statistics counters.
// PARAMETERS
//  MAX_PAYLOAD    1472  largest legal payload length in bytes (MTU 1500 - IP 20 - UDP 8)
//  NUM_ENDPOINTS  16    endpoint_id must be < NUM_ENDPOINTS; range 1..256
//  FIFO_DEPTH     4     output FIFO entries; power of 2, >= 2
//  CNT_W          16    width of the statistics counters
//  DROP_ON_ERR    1     1: discard bad beats; 0: enqueue bad beats with o_tag != 0
// PORTS
//  iClk           in   1   clock
//  iRst           in   1   synchronous reset, active-high
//  i_payload_len  in   16  payload length (bytes)
//  i_src_ip       in   32  source IPv4 address
//  i_dst_ip       in   32  destination IPv4 address
//  i_src_port     in   16  UDP source port
//  i_dst_port     in   16  UDP destination port
//  i_flags        in   8   opaque flags, passed through
//  i_endpoint_id  in   8   endpoint index
//  i_valid        in   1   input beat valid
//  o_ready        out  1   input accept; = !fifo_full
//  o_payload_len, o_src_ip, o_dst_ip, o_src_port, o_dst_port, o_flags, o_endpoint_id
//                 out  16/32/32/16/16/8/8  FIFO head fields
//  o_tag          out  4   error code of the head beat (0 = clean)
//  o_valid        out  1   FIFO non-empty
//  i_ready        in   1   downstream accept
//  o_error        out  1   1-cycle pulse, one cycle after a bad beat is accepted
//  o_error_code   out  4   code of the most recent bad beat; held until the next error or reset
//  i_cnt_clr      in   1   synchronous clear of both statistics counters
//  o_pass_cnt     out  CNT_W  clean beats accepted (saturating)
//  o_err_cnt      out  CNT_W  bad beats accepted (saturating)
//  o_level        out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset: FIFO empty; o_valid=0, o_level=0, o_error=0, o_error_code=0, counters=0, all data outputs and o_tag=0.
//   o_ready=1 in the first cycle after reset.
//  Accept: a beat is accepted when i_valid && o_ready at a clock edge. No internal state machine; pipeline state is FIFO plus counters.
//  Error code, combinational from inputs, first match wins:
//   1 len==0; 2 len>MAX_PAYLOAD; 3 src_ip==0; 4 dst_ip==0; 5 src_port==0; 6 dst_port==0;
//   7 endpoint_id>=NUM_ENDPOINTS; 0 otherwise.
//  Enqueue: a clean beat is always written. A bad beat is written only if DROP_ON_ERR==0, with tag = code.
//   Latency from accept to o_valid (empty FIFO) is 1 cycle. Data is held stable while o_valid && !i_ready.
//  Dequeue: pop on o_valid && i_ready. o_valid is driven from FIFO state only, never from i_valid.
//  Full: o_ready=0. A pop in the same cycle does not reopen o_ready until the next cycle (no full-cycle bypass).
//  Simultaneous push and pop on a non-full, non-empty FIFO: level unchanged, order preserved.
//  Pointers wrap modulo FIFO_DEPTH.
//  Counters: increment on accept (pass or err), saturate at all-ones.
//   i_cnt_clr has priority over an increment in the same cycle; result is 0.
//  o_error: asserted for exactly one cycle after each bad accept, also for back-to-back bad beats (stays high, code updates).
//  Reset mid-operation: FIFO contents are discarded and all outputs return to reset values on the next edge.
// TESTING
//  1 Reset, then one beat len=64, IPs/ports nonzero, ep=3 -> o_valid next cycle, o_tag=0, o_pass_cnt=1.
//  2 len=1473 (DROP_ON_ERR=1) -> no enqueue, o_error pulse 1 cycle, o_error_code=2, o_err_cnt=1; len=0 with src_ip=0 -> code 1.
//  3 DROP_ON_ERR=0, ep=16 -> beat enqueued with o_tag=7; o_error_code=7.
//  4 i_ready=0, 5 beats streamed (depth 4) -> 4 accepted, o_ready=0, o_level=4; release i_ready -> FIFO order 1..4, 5th accepted a cycle later.
//  5 Continuous i_valid and i_ready for 100 clean beats -> 100 outputs, no bubbles after the first, o_pass_cnt=100.
//  6 CNT_W=4: 20 clean beats -> o_pass_cnt=15; i_cnt_clr with a concurrent accept -> 0; iRst with FIFO half full -> o_valid=0 next cycle.

Source files
------------

// File: rtl/rdma_meta_checker.sv
// TX metadata checker: validates each beat in one cycle, queues results in an output FIFO
// and keeps saturating pass/error statistics.
module rdma_meta_checker #(
  parameter int unsigned MAX_PAYLOAD   = 1472,
  parameter int unsigned NUM_ENDPOINTS = 16,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned CNT_W         = 16,
  parameter bit          DROP_ON_ERR   = 1'b1
) (
  input  logic                          iClk,
  input  logic                          iRst,
  input  logic [15:0]                   i_payload_len,
  input  logic [31:0]                   i_src_ip,
  input  logic [31:0]                   i_dst_ip,
  input  logic [15:0]                   i_src_port,
  input  logic [15:0]                   i_dst_port,
  input  logic [7:0]                    i_flags,
  input  logic [7:0]                    i_endpoint_id,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic [15:0]                   o_payload_len,
  output logic [31:0]                   o_src_ip,
  output logic [31:0]                   o_dst_ip,
  output logic [15:0]                   o_src_port,
  output logic [15:0]                   o_dst_port,
  output logic [7:0]                    o_flags,
  output logic [7:0]                    o_endpoint_id,
  output logic [3:0]                    o_tag,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          o_error,
  output logic [3:0]                    o_error_code,
  input  logic                          i_cnt_clr,
  output logic [CNT_W-1:0]              o_pass_cnt,
  output logic [CNT_W-1:0]              o_err_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [15:0] payload_len;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [7:0]  flags;
    logic [7:0]  endpoint_id;
    logic [3:0]  tag;
  } beat_t;

  beat_t         mem [FIFO_DEPTH];
  beat_t         in_beat;
  beat_t         head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [3:0]    code;
  logic          accept;
  logic          push;
  logic          pop;

  // First failing rule wins, so the order of this chain is the code priority.
  always_comb begin
    code = 4'd0;
    if (i_payload_len == '0)                             code = 4'd1;
    else if (32'(i_payload_len) > MAX_PAYLOAD)           code = 4'd2;
    else if (i_src_ip == '0)                             code = 4'd3;
    else if (i_dst_ip == '0)                             code = 4'd4;
    else if (i_src_port == '0)                           code = 4'd5;
    else if (i_dst_port == '0)                           code = 4'd6;
    else if (32'(i_endpoint_id) >= NUM_ENDPOINTS)        code = 4'd7;
  end

  assign o_ready = (count != FULL_LVL);
  assign o_valid = (count != '0);
  assign o_level = count;
  assign accept  = i_valid && o_ready;
  assign push    = accept && ((code == 4'd0) || !DROP_ON_ERR);
  assign pop     = o_valid && i_ready;

  assign in_beat = '{payload_len: i_payload_len, src_ip: i_src_ip, dst_ip: i_dst_ip,
                     src_port: i_src_port, dst_port: i_dst_port, flags: i_flags,
                     endpoint_id: i_endpoint_id, tag: code};

  always_ff @(posedge iClk) begin
    if (push) mem[wr_ptr] <= in_beat;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Head is zeroed while empty so stale entries never appear on the outputs.
  assign head          = o_valid ? mem[rd_ptr] : '0;
  assign o_payload_len = head.payload_len;
  assign o_src_ip      = head.src_ip;
  assign o_dst_ip      = head.dst_ip;
  assign o_src_port    = head.src_port;
  assign o_dst_port    = head.dst_port;
  assign o_flags       = head.flags;
  assign o_endpoint_id = head.endpoint_id;
  assign o_tag         = head.tag;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      o_error      <= 1'b0;
      o_error_code <= '0;
    end else begin
      o_error <= accept && (code != 4'd0);
      if (accept && (code != 4'd0)) o_error_code <= code;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst || i_cnt_clr) begin
      o_pass_cnt <= '0;
      o_err_cnt  <= '0;
    end else if (accept) begin
      if (code == 4'd0) begin
        if (o_pass_cnt != '1) o_pass_cnt <= o_pass_cnt + 1'b1;
      end else begin
        if (o_err_cnt != '1) o_err_cnt <= o_err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rdma_meta_checker.sv
// Bench for rdma_meta_checker: a drop-mode/16-bit instance and a tag-mode/4-bit instance
// share stimulus; each is checked against a queue-based model every cycle.
`timescale 1ns/1ps
module tb_rdma_meta_checker;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic [15:0] i_payload_len;
  logic [31:0] i_src_ip;
  logic [31:0] i_dst_ip;
  logic [15:0] i_src_port;
  logic [15:0] i_dst_port;
  logic [7:0]  i_flags;
  logic [7:0]  i_endpoint_id;
  logic        i_valid;
  logic        i_ready;
  logic        i_cnt_clr;

  always #5 iClk = ~iClk;

  typedef struct packed {
    logic         valid;
    logic         ready;
    logic [2:0]   level;
    logic [131:0] head;
    logic         error;
    logic [3:0]   ecode;
    logic [15:0]  pass;
    logic [15:0]  errc;
  } obs_t;

  obs_t        act [2];
  obs_t        expv [2];
  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  bit          chk_on = 1'b0;

  function automatic logic [3:0] rule_code(input logic [15:0] len, input logic [31:0] s,
                                           input logic [31:0] d, input logic [15:0] sp,
                                           input logic [15:0] dp, input logic [7:0] ep);
    if (len == 16'd0)    return 4'd1;
    if (len > 16'd1472)  return 4'd2;
    if (s == 32'd0)      return 4'd3;
    if (d == 32'd0)      return 4'd4;
    if (sp == 16'd0)     return 4'd5;
    if (dp == 16'd0)     return 4'd6;
    if (ep >= 8'd16)     return 4'd7;
    return 4'd0;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam bit          DROP = (g == 0);
    localparam int unsigned CW   = (g == 0) ? 16 : 4;

    logic          o_ready, o_valid, o_error;
    logic [15:0]   o_payload_len, o_src_port, o_dst_port;
    logic [31:0]   o_src_ip, o_dst_ip;
    logic [7:0]    o_flags, o_endpoint_id;
    logic [3:0]    o_tag, o_error_code;
    logic [CW-1:0] o_pass_cnt, o_err_cnt;
    logic [2:0]    o_level;

    rdma_meta_checker #(
      .MAX_PAYLOAD(1472), .NUM_ENDPOINTS(16), .FIFO_DEPTH(4), .CNT_W(CW), .DROP_ON_ERR(DROP)
    ) dut (
      .iClk(iClk), .iRst(iRst),
      .i_payload_len(i_payload_len), .i_src_ip(i_src_ip), .i_dst_ip(i_dst_ip),
      .i_src_port(i_src_port), .i_dst_port(i_dst_port), .i_flags(i_flags),
      .i_endpoint_id(i_endpoint_id), .i_valid(i_valid), .o_ready(o_ready),
      .o_payload_len(o_payload_len), .o_src_ip(o_src_ip), .o_dst_ip(o_dst_ip),
      .o_src_port(o_src_port), .o_dst_port(o_dst_port), .o_flags(o_flags),
      .o_endpoint_id(o_endpoint_id), .o_tag(o_tag), .o_valid(o_valid), .i_ready(i_ready),
      .o_error(o_error), .o_error_code(o_error_code), .i_cnt_clr(i_cnt_clr),
      .o_pass_cnt(o_pass_cnt), .o_err_cnt(o_err_cnt), .o_level(o_level)
    );

    assign act[g] = {o_valid, o_ready, o_level, o_payload_len, o_src_ip, o_dst_ip, o_src_port,
                     o_dst_port, o_flags, o_endpoint_id, o_tag, o_error, o_error_code,
                     16'(o_pass_cnt), 16'(o_err_cnt)};

    logic [131:0] q [$];
    int unsigned  m_pass, m_err;
    logic         m_errp;
    logic [3:0]   m_code;
    obs_t         m_obs;

    assign expv[g] = m_obs;

    always @(posedge iClk) begin
      logic [3:0]  c;
      bit          acc, pp;
      int unsigned maxv;
      maxv = (1 << CW) - 1;
      if (iRst) begin
        q.delete();
        m_pass = 0; m_err = 0; m_errp = 1'b0; m_code = 4'd0;
      end else begin
        c   = rule_code(i_payload_len, i_src_ip, i_dst_ip, i_src_port, i_dst_port, i_endpoint_id);
        acc = i_valid && (q.size() < 4);
        pp  = (q.size() != 0) && i_ready;
        if (pp) void'(q.pop_front());
        if (acc && (c == 4'd0 || !DROP))
          q.push_back({i_payload_len, i_src_ip, i_dst_ip, i_src_port, i_dst_port,
                       i_flags, i_endpoint_id, c});
        m_errp = acc && (c != 4'd0);
        if (m_errp) m_code = c;
        if (i_cnt_clr) begin
          m_pass = 0; m_err = 0;
        end else if (acc) begin
          if (c == 4'd0) begin
            if (m_pass < maxv) m_pass++;
          end else if (m_err < maxv) m_err++;
        end
      end
      m_obs = {q.size() != 0, q.size() < 4, 3'(q.size()),
               (q.size() != 0) ? q[0] : 132'd0, m_errp, m_code, 16'(m_pass), 16'(m_err)};
    end
  end

  task automatic check(input string nm, input logic [131:0] a, input logic [131:0] e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic compare_all();
    for (int g = 0; g < 2; g++) begin
      check($sformatf("i%0d.valid", g), 132'(act[g].valid), 132'(expv[g].valid));
      check($sformatf("i%0d.ready", g), 132'(act[g].ready), 132'(expv[g].ready));
      check($sformatf("i%0d.level", g), 132'(act[g].level), 132'(expv[g].level));
      check($sformatf("i%0d.head", g),  act[g].head,        expv[g].head);
      check($sformatf("i%0d.error", g), 132'(act[g].error), 132'(expv[g].error));
      check($sformatf("i%0d.ecode", g), 132'(act[g].ecode), 132'(expv[g].ecode));
      check($sformatf("i%0d.pass", g),  132'(act[g].pass),  132'(expv[g].pass));
      check($sformatf("i%0d.errc", g),  132'(act[g].errc),  132'(expv[g].errc));
    end
  endtask

  task automatic tick();
    @(negedge iClk);
    if (chk_on) compare_all();
  endtask

  task automatic beat(input logic [15:0] len, input logic [31:0] s, input logic [31:0] d,
                      input logic [15:0] sp, input logic [15:0] dp, input logic [7:0] ep);
    i_payload_len = len; i_src_ip = s; i_dst_ip = d;
    i_src_port = sp; i_dst_port = dp; i_endpoint_id = ep;
    i_flags = len[7:0] ^ 8'hA5;
    i_valid = 1'b1;
  endtask

  task automatic send(input logic [15:0] len, input logic [31:0] s, input logic [31:0] d,
                      input logic [15:0] sp, input logic [15:0] dp, input logic [7:0] ep);
    int n;
    beat(len, s, d, sp, dp, ep);
    n = 0;
    while (!act[0].ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) begin
      n_cmp++; n_fail++;
      $display("FAIL send_wait: got ready=0 for 20 cycles expected ready=1");
    end
    tick();
    i_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bubbles, outs;
    i_valid = 1'b0; i_ready = 1'b1; i_cnt_clr = 1'b0;
    beat(16'd0, 32'd0, 32'd0, 16'd0, 16'd0, 8'd0);
    i_valid = 1'b0;
    iRst = 1'b1;
    tick();
    chk_on = 1'b1;
    tick();
    iRst = 1'b0;
    check("rst.valid", 132'(act[0].valid), 132'd0);
    check("rst.ready", 132'(act[0].ready), 132'd1);
    check("rst.level", 132'(act[0].level), 132'd0);
    check("rst.head",  act[0].head,        132'd0);

    // clean beat
    send(16'd64, 32'h0A000001, 32'h0A000002, 16'd1000, 16'd4791, 8'd3);
    check("t1.valid", 132'(act[0].valid), 132'd1);
    check("t1.tag",   132'(act[0].head[3:0]), 132'd0);
    check("t1.len",   132'(act[0].head[131:116]), 132'd64);
    check("t1.pass",  132'(act[0].pass), 132'd1);

    // oversize beat, then back-to-back bad beats
    send(16'd1473, 32'h0A000001, 32'h0A000002, 16'd1000, 16'd4791, 8'd3);
    check("t2.error", 132'(act[0].error), 132'd1);
    check("t2.ecode", 132'(act[0].ecode), 132'd2);
    check("t2.errc",  132'(act[0].errc),  132'd1);
    check("t2.drop",  132'(act[0].valid), 132'd0);
    check("t2.tag1",  132'(act[1].head[3:0]), 132'd2);
    tick();
    check("t2.pulse", 132'(act[0].error), 132'd0);
    check("t2.hold",  132'(act[0].ecode), 132'd2);
    beat(16'd0, 32'd0, 32'h0A000002, 16'd1, 16'd2, 8'd1);
    tick();
    check("t2.code1", 132'(act[0].ecode), 132'd1);
    beat(16'd1472, 32'h0A000001, 32'd0, 16'd1, 16'd2, 8'd1);
    tick();
    i_valid = 1'b0;
    check("t2.b2b_err",  132'(act[0].error), 132'd1);
    check("t2.b2b_code", 132'(act[0].ecode), 132'd4);
    tick(); tick();

    // endpoint boundary
    send(16'd100, 32'hC0A80001, 32'hC0A80002, 16'd5, 16'd6, 8'd16);
    check("t3.valid1", 132'(act[1].valid), 132'd1);
    check("t3.tag1",   132'(act[1].head[3:0]), 132'd7);
    check("t3.ecode1", 132'(act[1].ecode), 132'd7);
    check("t3.drop0",  132'(act[0].valid), 132'd0);
    send(16'd100, 32'hC0A80001, 32'hC0A80002, 16'd5, 16'd6, 8'd15);
    check("t3.ep15",   132'(act[0].valid), 132'd1);
    tick(); tick(); tick();

    // fill with downstream stalled
    i_ready = 1'b0;
    for (int k = 1; k <= 4; k++)
      send(16'(k), 32'h01020304, 32'h05060708, 16'(k), 16'd80, 8'(k));
    check("t4.level", 132'(act[0].level), 132'd4);
    check("t4.full",  132'(act[0].ready), 132'd0);
    beat(16'd5, 32'h01020304, 32'h05060708, 16'd5, 16'd80, 8'd5);
    tick(); tick();
    check("t4.stall", 132'(act[0].head[131:116]), 132'd1);
    i_ready = 1'b1;
    tick();
    check("t4.h2",    132'(act[0].head[131:116]), 132'd2);
    check("t4.lvl3",  132'(act[0].level), 132'd3);
    tick();
    i_valid = 1'b0;
    check("t4.h3",    132'(act[0].head[131:116]), 132'd3);
    check("t4.lvl3b", 132'(act[0].level), 132'd3);
    tick();
    check("t4.h4",    132'(act[0].head[131:116]), 132'd4);
    tick();
    check("t4.h5",    132'(act[0].head[131:116]), 132'd5);
    tick();
    check("t4.empty", 132'(act[0].valid), 132'd0);

    // streaming
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    bubbles = 0; outs = 0;
    for (int i = 0; i < 100; i++) begin
      beat(16'(100 + i), 32'(i + 1), 32'h0B000001, 16'(2000 + i), 16'd4791, 8'(i % 16));
      tick();
      if (act[0].valid) outs++;
      else bubbles++;
    end
    i_valid = 1'b0;
    tick();
    check("t5.outs",    132'(outs), 132'd100);
    check("t5.bubbles", 132'(bubbles), 132'd0);
    check("t5.pass",    132'(act[0].pass), 132'd100);
    check("t5.sat4",    132'(act[1].pass), 132'd15);

    // clear vs accept, saturation, reset mid-operation
    beat(16'd200, 32'h0A000001, 32'h0A000002, 16'd9, 16'd9, 8'd0);
    i_cnt_clr = 1'b1;
    tick();
    i_cnt_clr = 1'b0;
    i_valid = 1'b0;
    check("t6.clr0", 132'(act[0].pass), 132'd0);
    check("t6.clr1", 132'(act[1].pass), 132'd0);
    check("t6.enq",  132'(act[0].valid), 132'd1);
    for (int i = 0; i < 20; i++) begin
      beat(16'(300 + i), 32'h0A000001, 32'h0A000002, 16'd9, 16'd9, 8'd2);
      tick();
    end
    i_valid = 1'b0;
    tick();
    check("t6.p20",  132'(act[0].pass), 132'd20);
    check("t6.sat",  132'(act[1].pass), 132'd15);
    i_ready = 1'b0;
    send(16'd7, 32'h0A000001, 32'h0A000002, 16'd9, 16'd9, 8'd2);
    send(16'd8, 32'h0A000001, 32'h0A000002, 16'd9, 16'd9, 8'd2);
    check("t6.half", 132'(act[0].level), 132'd2);
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    i_ready = 1'b1;
    check("t6.rst_valid", 132'(act[0].valid), 132'd0);
    check("t6.rst_level", 132'(act[0].level), 132'd0);
    check("t6.rst_pass",  132'(act[0].pass),  132'd0);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
